// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes and default bit timing.
// Used by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // 25 MHz system clock / 115200 baud
  localparam int CLKS_PER_BIT = 217;

  function automatic logic parity_bit(input logic [7:0] data, input int mode);
    return (^data) ^ (mode == PARITY_ODD);
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Serial bit timer: counts 0..clks_per_bit-1 while enabled and ticks on the final
// cycle of each bit. Clear holds the count at zero so a new bit starts aligned.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int clks_per_bit = CLKS_PER_BIT
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_tick
);

  localparam int CNT_W = (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(clks_per_bit - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clear) begin
      cnt_d = '0;
    end else if (i_enable) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_tick = i_enable && !i_clear && (cnt_q == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter with a one-entry holding register, optional parity and 1 or 2
// stop bits. All outputs are registered from the current FSM state.
module uart_tx
  import uart_pkg::*;
#(
  parameter int clks_per_bit = CLKS_PER_BIT,
  parameter int parity_mode  = PARITY_NONE,
  parameter int stop_bits    = 1
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_tx_dv,
  input  logic [7:0] i_tx_byte,
  output logic       o_tx_ready,
  output logic       o_tx_active,
  output logic       o_tx_done,
  output logic       o_tx_serial
);

  localparam logic [2:0] LAST_STOP = 3'(stop_bits - 1);

  uart_state_e state_q, state_d;
  logic        hold_full_q, hold_full_d;
  logic [7:0]  hold_byte_q, hold_byte_d;
  logic [7:0]  shift_q, shift_d;
  logic        parity_q, parity_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic        serial_q, serial_d;
  logic        active_q, active_d;
  logic        done_q, done_d;
  logic        tick;
  logic        accept;
  logic        load;

  assign accept = i_tx_dv && !hold_full_q;

  uart_bit_timer #(
    .clks_per_bit(clks_per_bit)
  ) u_bit_timer (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_clear (state_q == IDLE),
    .i_enable(state_q != IDLE),
    .o_tick  (tick)
  );

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    bit_idx_d   = bit_idx_q;
    hold_full_d = hold_full_q;
    hold_byte_d = hold_byte_q;
    load        = 1'b0;

    case (state_q)
      IDLE: begin
        if (hold_full_q) begin
          load    = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (tick) begin
          state_d   = DATA;
          bit_idx_d = '0;
        end
      end
      DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == 3'd7) begin
            bit_idx_d = '0;
            state_d   = (parity_mode != PARITY_NONE) ? PARITY : STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      PARITY: begin
        if (tick) begin
          state_d   = STOP;
          bit_idx_d = '0;
        end
      end
      STOP: begin
        if (tick) begin
          if (bit_idx_q == LAST_STOP) begin
            bit_idx_d = '0;
            // A queued byte starts its frame straight away: no idle bit between frames
            if (hold_full_q) begin
              load    = 1'b1;
              state_d = START;
            end else begin
              state_d = IDLE;
            end
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      shift_d     = hold_byte_q;
      parity_d    = parity_bit(hold_byte_q, parity_mode);
      hold_full_d = 1'b0;
    end
    // accept needs an empty register and load a full one, so they never coincide
    if (accept) begin
      hold_full_d = 1'b1;
      hold_byte_d = i_tx_byte;
    end
  end

  always_comb begin
    serial_d = 1'b1;
    case (state_q)
      START:   serial_d = 1'b0;
      DATA:    serial_d = shift_q[0];
      PARITY:  serial_d = parity_q;
      default: serial_d = 1'b1;
    endcase
    active_d = (state_q != IDLE);
    done_d   = (state_q == STOP) && tick && (bit_idx_q == LAST_STOP);
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q     <= IDLE;
      hold_full_q <= 1'b0;
      bit_idx_q   <= '0;
      serial_q    <= 1'b1;
      active_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_full_q <= hold_full_d;
      bit_idx_q   <= bit_idx_d;
      serial_q    <= serial_d;
      active_q    <= active_d;
      done_q      <= done_d;
    end
  end

  always_ff @(posedge i_clock) begin
    hold_byte_q <= hold_byte_d;
    shift_q     <= shift_d;
    parity_q    <= parity_d;
  end

  assign o_tx_ready  = !hold_full_q;
  assign o_tx_active = active_q;
  assign o_tx_done   = done_q;
  assign o_tx_serial = serial_q;

endmodule
